// File: rtl/text_buffer.sv
// text_buffer: character-cell store and cursor engine feeding the pixel shader.
// Accepts put-char / newline / clear / home commands over valid/ready, scrolls
// with a circular top-row pointer, and returns {char, color} for the beam
// coordinate one cycle later, together with the delayed coordinate.
// Optional feature: define TEXT_BUFFER_CURSOR_EN for a blinking cursor overlay.
module text_buffer #(
  parameter int COLS = 16,
  parameter int ROWS = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [1:0] i_cmd,
  input  logic [7:0] i_data,
  output logic [5:0] o_char,
  output logic [1:0] o_color,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_cursor
);

  localparam int NCELL = ROWS * COLS;
  localparam int AW    = $clog2(NCELL);
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLR_ROW = 2'd1,
    ST_CLR_ALL = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CMD_PUT  = 2'b00,
    CMD_NL   = 2'b01,
    CMD_CLR  = 2'b10,
    CMD_HOME = 2'b11
  } cmd_e;

  // Logical row -> physical row, wrapping by compare/subtract so any ROWS works.
  function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] top,
                                             input logic [6:0]    lrow);
    logic [7:0] sum;
    sum = 8'(top) + 8'(lrow);
    if (sum >= 8'(ROWS)) sum = sum - 8'(ROWS);
    return RW'(sum);
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] prow,
                                              input logic [6:0]    col);
    return AW'(prow) * AW'(COLS) + AW'(col);
  endfunction

  // Control state
  state_e        state_q;
  logic [RW-1:0] top_q;
  logic [CW-1:0] cur_col_q;
  logic [RW-1:0] cur_row_q;
  logic [AW-1:0] clr_q;
  logic [RW-1:0] clr_row_q;
  logic          ready_q;

  // Cell storage
  logic [7:0]    mem [NCELL];

  // Read-path output registers
  logic [5:0]    char_q;
  logic [1:0]    color_q;
  logic [9:0]    x_q;
  logic [9:0]    y_q;
  logic          cursor_q;

  cmd_e          cmd;
  logic          accept;
  logic          col_last;
  logic          adv_row;

  assign cmd      = cmd_e'(i_cmd);
  assign accept   = i_valid && ready_q;
  assign col_last = (cur_col_q == CW'(COLS - 1));
  assign adv_row  = accept && (((cmd == CMD_PUT) && col_last) || (cmd == CMD_NL));

  // Single write port: accepted put-char in IDLE, zero fill while clearing.
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept && (cmd == CMD_PUT)) begin
          mem_we    = 1'b1;
          mem_waddr = cell_addr(phys_row(top_q, 7'(cur_row_q)), 7'(cur_col_q));
          mem_wdata = i_data;
        end
      end
      ST_CLR_ROW: begin
        mem_we    = 1'b1;
        mem_waddr = cell_addr(clr_row_q, 7'(clr_q));
      end
      ST_CLR_ALL: begin
        mem_we    = 1'b1;
        mem_waddr = clr_q;
      end
      default: ;
    endcase
    if (i_rst) mem_we = 1'b0;
  end

  // Cell array write.
  // NOTE: the array has no reset; the CLR_ALL sweep after reset zeroes it, which keeps it mappable to RAM.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Command FSM: cursor, top pointer, clear sequencing and o_ready.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_CLR_ALL;
      top_q     <= '0;
      cur_col_q <= '0;
      cur_row_q <= '0;
      clr_q     <= '0;
      clr_row_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (cmd)
              CMD_PUT:  cur_col_q <= col_last ? '0 : cur_col_q + CW'(1);
              CMD_NL:   cur_col_q <= '0;
              CMD_CLR: begin
                cur_col_q <= '0;
                cur_row_q <= '0;
                top_q     <= '0;
                clr_q     <= '0;
                state_q   <= ST_CLR_ALL;
                ready_q   <= 1'b0;
              end
              CMD_HOME: begin
                cur_col_q <= '0;
                cur_row_q <= '0;
              end
              default: ;
            endcase
            if (adv_row) begin
              if (cur_row_q < RW'(ROWS - 1)) begin
                cur_row_q <= cur_row_q + RW'(1);
              end else begin
                // Scroll: old top becomes the new bottom row and is wiped.
                top_q     <= (top_q == RW'(ROWS - 1)) ? '0 : top_q + RW'(1);
                clr_row_q <= top_q;
                clr_q     <= '0;
                state_q   <= ST_CLR_ROW;
                ready_q   <= 1'b0;
              end
            end
          end
        end
        ST_CLR_ROW: begin
          if (clr_q == AW'(COLS - 1)) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end else begin
            clr_q <= clr_q + AW'(1);
          end
        end
        ST_CLR_ALL: begin
          if (clr_q == AW'(NCELL - 1)) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end else begin
            clr_q <= clr_q + AW'(1);
          end
        end
        default: begin
          state_q <= ST_CLR_ALL;
          clr_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Read address decode for the current beam coordinate.
  logic [6:0]    rd_col;
  logic [6:0]    rd_lrow;
  logic          rd_in;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_cell;
  logic          cursor_hit;

  always_comb begin
    rd_col  = i_x[9:3];
    rd_lrow = i_y[9:3];
    rd_in   = (i_x < 10'(8 * COLS)) && (i_y < 10'(8 * ROWS));
    rd_addr = rd_in ? cell_addr(phys_row(top_q, rd_lrow), rd_col) : '0;
    rd_cell = mem[rd_addr];
  end

`ifdef TEXT_BUFFER_CURSOR_EN
  logic [4:0] frame_q;

  // Frame counter: one tick per frame origin; MSB is the blink phase.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_q <= '0;
    end else if ((i_x == 10'd0) && (i_y == 10'd0)) begin
      frame_q <= frame_q + 5'd1;
    end
  end

  assign cursor_hit = rd_in && frame_q[4] &&
                      (rd_col == 7'(cur_col_q)) && (rd_lrow == 7'(cur_row_q));
`else
  assign cursor_hit = 1'b0;
`endif

  // Output stage: cell data, overlay and coordinates all from one sample.
  // NOTE: non-blocking update means a same-cycle write to this cell is not seen; the read returns old contents.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      char_q   <= '0;
      color_q  <= 2'b11;
      x_q      <= '0;
      y_q      <= '0;
      cursor_q <= 1'b0;
    end else begin
      x_q      <= i_x;
      y_q      <= i_y;
      cursor_q <= cursor_hit;
      if (rd_in) begin
        char_q  <= rd_cell[5:0];
        color_q <= cursor_hit ? 2'b01 : rd_cell[7:6];
      end else begin
        char_q  <= '0;
        color_q <= 2'b11;
      end
    end
  end

  assign o_ready  = ready_q;
  assign o_char   = char_q;
  assign o_color  = color_q;
  assign o_x      = x_q;
  assign o_y      = y_q;
  assign o_cursor = cursor_q;

endmodule

// File: tb/tb_text_buffer.sv
// tb_text_buffer: directed self-checking bench for text_buffer (COLS=16, ROWS=8).
// Expected cursor-overlay results follow TEXT_BUFFER_CURSOR_EN when defined.
module tb_text_buffer;

  localparam logic [1:0] PUT  = 2'b00;
  localparam logic [1:0] NL   = 2'b01;
  localparam logic [1:0] CLR  = 2'b10;
  localparam logic [1:0] HOME = 2'b11;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [9:0] i_x = '0;
  logic [9:0] i_y = '0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [1:0] i_cmd = '0;
  logic [7:0] i_data = '0;
  logic [5:0] o_char;
  logic [1:0] o_color;
  logic [9:0] o_x;
  logic [9:0] o_y;
  logic       o_cursor;

  int tests = 0;
  int fails = 0;

  text_buffer #(.COLS(16), .ROWS(8)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_x      (i_x),
    .i_y      (i_y),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_cmd    (i_cmd),
    .i_data   (i_data),
    .o_char   (o_char),
    .o_color  (o_color),
    .o_x      (o_x),
    .o_y      (o_y),
    .o_cursor (o_cursor)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [1:0] cmd, input logic [7:0] data);
    int n = 0;
    while (!o_ready && n < 1000) begin
      step();
      n++;
    end
    check("send_ready", o_ready, 1'b1);
    i_cmd   = cmd;
    i_data  = data;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
  endtask

  // Counts post-edge samples with o_ready low until it rises (bounded).
  task automatic count_busy(output int n);
    n = 0;
    while (!o_ready && n < 400) begin
      step();
      n++;
    end
  endtask

  task automatic read(input logic [9:0] x, input logic [9:0] y);
    i_x = x;
    i_y = y;
    step();
  endtask

  task automatic expect_cell(input string tag, input logic [9:0] x, input logic [9:0] y,
                             input logic [5:0] ch, input logic [1:0] col);
    read(x, y);
    check({tag, "_char"}, o_char, ch);
    check({tag, "_color"}, o_color, col);
  endtask

  function automatic logic [7:0] sig(input int r);
    return 8'((r % 4) * 64 + r + 1);
  endfunction

  initial begin
    int n;
    int bad;

    // Reset state, with non-zero beam inputs to show the outputs are held.
    i_x = 10'd5;
    i_y = 10'd7;
    step();
    step();
    check("rst_ready", o_ready, 1'b0);
    check("rst_char", o_char, 6'h00);
    check("rst_color", o_color, 2'b11);
    check("rst_x", o_x, 10'd0);
    check("rst_y", o_y, 10'd0);
    check("rst_cursor", o_cursor, 1'b0);

    // Release with a request held; it must be ignored for the whole clear.
    i_cmd   = HOME;
    i_valid = 1'b1;
    i_rst   = 1'b0;
    count_busy(n);
    i_valid = 1'b0;
    check("init_clear_cycles", n, 128);

    bad = 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 16; c++) begin
        read(10'(c * 8 + 3), 10'(r * 8 + 3));
        if (o_char !== 6'h00 || o_color !== 2'b00) bad++;
      end
    end
    check("init_cells_zero", bad, 0);

    // First put-char at home, read one cycle later.
    send(PUT, 8'h85);
    read(10'd3, 10'd5);
    check("put85_char", o_char, 6'h05);
    check("put85_color", o_color, 2'b10);
    check("put85_x", o_x, 10'd3);
    check("put85_y", o_y, 10'd5);

    // Write and read of the same cell in one cycle returns old contents.
    i_x     = 10'd8;
    i_y     = 10'd0;
    i_cmd   = PUT;
    i_data  = 8'h4A;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    check("same_cycle_old_char", o_char, 6'h00);
    expect_cell("after_write", 10'd8, 10'd0, 6'h0A, 2'b01);

    // 17 chars from home: the 17th wraps to row 1, column 0.
    send(HOME, 8'h00);
    for (int i = 0; i < 17; i++) send(PUT, 8'(64 + i + 1));
    expect_cell("wrap_char17", 10'd3, 10'd11, 6'h11, 2'b01);
    expect_cell("row0_col15", 10'd123, 10'd3, 6'h10, 2'b01);
    send(PUT, 8'hC2);
    expect_cell("row1_col1", 10'd11, 10'd11, 6'h02, 2'b11);

    // Fill rows 0..6, one char on row 7, then newline on row 7 scrolls.
    send(HOME, 8'h00);
    for (int r = 0; r < 7; r++) begin
      for (int c = 0; c < 16; c++) send(PUT, sig(r));
    end
    send(PUT, 8'hC8);
    send(NL, 8'h00);
    count_busy(n);
    check("scroll_busy_cycles", n, 16);
    expect_cell("scroll_lrow0", 10'd43, 10'd3, 6'h02, 2'b01);
    expect_cell("scroll_lrow4", 10'd3, 10'd35, 6'h06, 2'b01);
    expect_cell("scroll_lrow6", 10'd3, 10'd51, 6'h08, 2'b11);
    expect_cell("scroll_lrow7_cleared", 10'd43, 10'd59, 6'h00, 2'b00);
    send(PUT, 8'h17);
    expect_cell("put_after_scroll", 10'd3, 10'd59, 6'h17, 2'b00);

    // Out-of-range coordinates are blank; the last in-range cell is not.
    expect_cell("blank_x128", 10'd128, 10'd0, 6'h00, 2'b11);
    expect_cell("blank_y64", 10'd0, 10'd64, 6'h00, 2'b11);
    expect_cell("edge_127_63", 10'd127, 10'd63, 6'h00, 2'b00);

    // Clear screen: 128 busy cycles, cursor and top back to origin.
    send(CLR, 8'h00);
    count_busy(n);
    check("clear_busy_cycles", n, 128);
    expect_cell("clear_old_c8", 10'd3, 10'd59, 6'h00, 2'b00);
    send(PUT, 8'hA5);
    expect_cell("clear_home_put", 10'd3, 10'd3, 6'h25, 2'b10);

    // Home: cursor returns to (0,0) without touching contents.
    send(HOME, 8'h00);
    expect_cell("home_keeps_a5", 10'd3, 10'd3, 6'h25, 2'b10);
    send(PUT, 8'h3F);
    expect_cell("home_put", 10'd3, 10'd3, 6'h3F, 2'b00);
    expect_cell("home_col1", 10'd11, 10'd3, 6'h00, 2'b00);

    // Reset in the middle of a clear restarts the full clear.
    i_x = 10'd500;
    i_y = 10'd500;
    send(CLR, 8'h00);
    for (int i = 0; i < 40; i++) step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    count_busy(n);
    check("midclear_reset_cycles", n, 128);

    // Cursor at column 2, row 0; blink phase 0 then 1.
    send(PUT, 8'h81);
    send(PUT, 8'h82);
    read(10'd16, 10'd0);
    check("cursor_phase0", o_cursor, 1'b0);
    check("cursor_phase0_color", o_color, 2'b00);
    i_x = 10'd0;
    i_y = 10'd0;
    for (int i = 0; i < 16; i++) step();
    read(10'd16, 10'd0);
    check("cursor_cell_char", o_char, 6'h00);
`ifdef TEXT_BUFFER_CURSOR_EN
    check("cursor_phase1", o_cursor, 1'b1);
    check("cursor_phase1_color", o_color, 2'b01);
`else
    check("cursor_phase1", o_cursor, 1'b0);
    check("cursor_phase1_color", o_color, 2'b00);
`endif
    read(10'd8, 10'd0);
    check("noncursor_cursor", o_cursor, 1'b0);
    check("noncursor_color", o_color, 2'b10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
